// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, external hold,
// and branch flush (a flush seen during hold is remembered until hold drops).
module id_ex_stage_reg #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [ADDR_W-1:0]   id_src1_add,
    input  logic [ADDR_W-1:0]   id_src2_add,
    input  logic [ADDR_W-1:0]   id_dst_add,
    input  logic [DATA_W-1:0]   id_rd1,
    input  logic [DATA_W-1:0]   id_rd2,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic                id_wb,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_cin,
    input  logic                id_ldm,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                hold,
    input  logic                flush,
    output logic                ex_valid,
    output logic                ex_wb,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_cin,
    output logic                ex_ldm,
    output logic [ADDR_W-1:0]   ex_src1_add,
    output logic [ADDR_W-1:0]   ex_src2_add,
    output logic [ADDR_W-1:0]   ex_dst_add,
    output logic [DATA_W-1:0]   ex_rd1,
    output logic [DATA_W-1:0]   ex_rd2,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                stall_if_id,
    output logic [15:0]         bubble_cnt
);

    typedef struct packed {
        logic                valid;
        logic                wb;
        logic                mem_read;
        logic                mem_write;
        logic                cin;
        logic                ldm;
        logic [ALU_OP_W-1:0] alu_op;
        logic [ADDR_W-1:0]   src1;
        logic [ADDR_W-1:0]   src2;
        logic [ADDR_W-1:0]   dst;
        logic [DATA_W-1:0]   rd1;
        logic [DATA_W-1:0]   rd2;
        logic [DATA_W-1:0]   imm;
    } stage_t;

    stage_t      id_pkt;
    stage_t      ex_q;
    logic        pend_flush;
    logic [15:0] bubble_cnt_q;
    logic        use1;
    logic        use2;
    logic        load_use;
    logic        flush_eff;

    // Pack decode-stage fields and evaluate the load-use hazard against EX
    always_comb begin
        id_pkt = '{valid: id_valid, wb: id_wb, mem_read: id_mem_read,
                   mem_write: id_mem_write, cin: id_cin, ldm: id_ldm,
                   alu_op: id_alu_op, src1: id_src1_add, src2: id_src2_add,
                   dst: id_dst_add, rd1: id_rd1, rd2: id_rd2, imm: id_imm};
        use1      = ~id_cin;
        use2      = ~id_ldm;
        load_use  = id_valid & ex_q.valid & ex_q.mem_read & ex_q.wb &
                    ((use1 & (id_src1_add == ex_q.dst)) |
                     (use2 & (id_src2_add == ex_q.dst)));
        flush_eff = flush | pend_flush;
    end

    // Stage register: reset > hold > flush > load-use bubble > normal load
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= '0;
            pend_flush   <= 1'b0;
            bubble_cnt_q <= '0;
        end else if (hold) begin
            if (flush) pend_flush <= 1'b1;
        end else if (flush_eff) begin
            ex_q       <= '0;
            pend_flush <= 1'b0;
        end else if (load_use) begin
            ex_q <= '0;
            if (bubble_cnt_q != 16'hFFFF) bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end else begin
            ex_q <= id_pkt;
        end
    end

    assign stall_if_id  = hold | (load_use & ~flush_eff);
    assign bubble_cnt   = bubble_cnt_q;
    assign ex_valid     = ex_q.valid;
    assign ex_wb        = ex_q.wb;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_cin       = ex_q.cin;
    assign ex_ldm       = ex_q.ldm;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_src1_add  = ex_q.src1;
    assign ex_src2_add  = ex_q.src2;
    assign ex_dst_add   = ex_q.dst;
    assign ex_rd1       = ex_q.rd1;
    assign ex_rd2       = ex_q.rd2;
    assign ex_imm       = ex_q.imm;

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register of the five-stage processor. It captures decoded operands, register addresses and control bits from the decode stage and presents them, registered, to the execute stage and to the forwarding unit. It also contains the load-use hazard detector: it inserts a bubble and stalls IF/ID when a load in EX feeds the instruction in decode. It supports an external pipeline hold and a branch flush, including a flush that arrives during a hold.

## Interface
- DATA_W, 16, operand/immediate width
- ADDR_W, 3, register address width
- ALU_OP_W, 4, ALU opcode width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a real instruction
- id_src1_add, id_src2_add, id_dst_add  in  ADDR_W each  decode register addresses
- id_rd1, id_rd2, id_imm  in  DATA_W each  register-file reads and immediate
- id_wb, id_mem_read, id_mem_write, id_cin, id_ldm  in  1 each  decode control bits
- id_alu_op  in  ALU_OP_W  decode ALU opcode
- hold  in  1  downstream busy; freeze register
- flush  in  1  branch taken; discard decode instruction
- ex_valid, ex_wb, ex_mem_read, ex_mem_write, ex_cin, ex_ldm  out  1 each  registered control
- ex_src1_add, ex_src2_add, ex_dst_add  out  ADDR_W each  registered addresses (to forwarding unit)
- ex_rd1, ex_rd2, ex_imm  out  DATA_W each  registered data
- ex_alu_op  out  ALU_OP_W  registered opcode
- stall_if_id  out  1  combinational; upstream must hold PC and IF/ID this cycle
- bubble_cnt  out  16  saturating count of load-use bubbles inserted

## Operation
- Operand use: use1 = ~id_cin, use2 = ~id_ldm. An unused source never causes a hazard.
- load_use = id_valid & ex_valid & ex_mem_read & ex_wb & ((use1 & id_src1_add==ex_dst_add) | (use2 & id_src2_add==ex_dst_add)).
- flush_eff = flush | pend_flush.
- Register update priority each edge:
  - 1. rst: all outputs and pend_flush cleared to 0, bubble_cnt=0.
  - 2. hold: register contents unchanged. If flush=1, set pend_flush=1.
  - 3. flush_eff: load bubble, clear pend_flush.
  - 4. load_use: load bubble; bubble_cnt += 1, saturating at 0xFFFF.
  - 5. Otherwise: load all id_* inputs verbatim. ex_valid=id_valid.
- Bubble: ex_valid, ex_wb, ex_mem_read, ex_mem_write, ex_cin and ex_ldm are 0. ex_alu_op=0. Addresses and data are 0.
- stall_if_id = hold | (load_use & ~flush_eff).
- A flush together with a load-use hazard inserts exactly one bubble. It does not stall or increment bubble_cnt.
- A load-use hazard during hold inserts no bubble. It is re-evaluated on the first cycle after hold falls.
- Only a bubble is ever inserted on a load-use hazard, never a duplicate of the load. After one bubble the load is in MEM and the forwarding unit selects the M path. A single bubble therefore always resolves the hazard.

## Timing
- Latency: id_* presented in cycle N appear on ex_* after the edge ending cycle N, unless held or bubbled.
- stall_if_id is valid in the same cycle as id_* and the current ex_* contents. There is no registered delay.
- The load-use stall lasts exactly 1 cycle per load when hold=0.
- pend_flush persists across any number of hold cycles. It is applied on the first edge with hold=0 and rst=0.
- rst during hold or with pend_flush set clears everything on that edge. Outputs are 0 from the next cycle.
- Reset value of every output is 0. stall_if_id is 0 while ex_valid=0 and hold=0.

## Test plan
- Normal flow: id_valid=1, src1=2, src2=3, dst=4, id_rd1=0x1234, id_wb=1, no hazard -> next cycle ex_src1_add=2, ex_dst_add=4, ex_rd1=0x1234, ex_wb=1, stall_if_id=0.
- Load-use: EX holds a load (mem_read=1, wb=1, dst=5); decode src2=5, ldm=0 -> stall_if_id=1 that cycle. Next cycle is a bubble (ex_valid=0), bubble_cnt=1. The same decode instruction then loads with stall_if_id=0.
- Unused operand: EX load dst=5; decode src1=5 with id_cin=1 -> no stall, instruction loads directly.
- Flush under hold: hold=1 for 3 cycles, flush=1 in the first of them -> ex_* frozen for 3 cycles. On the first edge with hold=0 a bubble is loaded and pend_flush clears.
- Flush + load-use simultaneous -> one bubble, stall_if_id=0, bubble_cnt unchanged.
- Saturation/reset: force 0x10000 load-use bubbles -> bubble_cnt stays 0xFFFF. Assert rst mid-hold -> all outputs 0 next cycle.
